// File: rtl/debounce4.sv
// Four-channel 2-flop synchronizer and debouncer with registered levels and
// one-cycle rise/fall strobes per channel.
module debounce4 #(
    parameter int unsigned STABLE_CYCLES = 12000,
    parameter int unsigned CNT_WIDTH     = 14
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] btn,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic [3:0] rise,
    output logic [3:0] fall
);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [3:0] m_q;
    logic [3:0] s_q;
    logic [3:0] db;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= btn;
            s_q <= m_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 db_q, db_d;
        logic                 rise_q, rise_d;
        logic                 fall_q, fall_d;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q <= StLow;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                StLow: begin
                    if (s_q[i]) begin
                        state_d = StWaitHigh;
                        cnt_d   = CntOne;
                    end
                end
                StWaitHigh: begin
                    if (!s_q[i]) begin
                        // Bounce: drop all accumulated credit.
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StHigh: begin
                    if (!s_q[i]) begin
                        state_d = StWaitLow;
                        cnt_d   = CntOne;
                    end
                end
                StWaitLow: begin
                    if (s_q[i]) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StLow;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StLow;
                    cnt_d   = '0;
                end
            endcase
            // Level is registered alongside the state so outputs come straight from flops.
            db_d = (state_d == StHigh) || (state_d == StWaitLow);
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

    assign x0 = db[0];
    assign x1 = db[1];
    assign x2 = db[2];
    assign x3 = db[3];

endmodule
